// File: rtl/bictr_rr_sched_if.sv
// Bundle of requester-side and counter-side signals for the round-robin counter scheduler.
// The master modport is the scheduler's view; slave is the view of the requesters plus the shared counter.
interface bictr_rr_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_up;
  logic [NREQ*WIDTH-1:0] req_start;
  logic [NREQ*WIDTH-1:0] req_target;
  logic                  abort;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  aborted;
  logic                  busy;
  logic [WIDTH-1:0]      ctr_data;
  logic                  ctr_load;
  logic                  ctr_up_dn;
  logic                  ctr_cen;
  logic [WIDTH-1:0]      ctr_count_to;
  logic                  ctr_tercnt;

  modport master (
    input  req, req_up, req_start, req_target, abort, ctr_tercnt,
    output grant, done, aborted, busy,
    output ctr_data, ctr_load, ctr_up_dn, ctr_cen, ctr_count_to
  );

  modport slave (
    output req, req_up, req_start, req_target, abort, ctr_tercnt,
    input  grant, done, aborted, busy,
    input  ctr_data, ctr_load, ctr_up_dn, ctr_cen, ctr_count_to
  );
endinterface

// File: rtl/bictr_rr_sched.sv
// Round-robin scheduler granting one shared up/down counter to NREQ requesters, one
// counting run (start, target, direction) at a time, until the counter's terminal-count flag.
module bictr_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  bictr_rr_sched_if.master bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              busy_q, busy_d;
  logic              load_q, load_d;
  logic              up_dn_q, up_dn_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  cto_q, cto_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;

  logic [PW:0]       pick_s;
  logic [PW-1:0]     pick_idx_s;

  // Returns {found, index}; walking from the lowest priority down lets the highest priority overwrite last.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW:0]  res;
    logic [31:0]  k;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = (32'(p) + 32'(i)) % 32'(NREQ);
      if (r[k[PW-1:0]]) begin
        res = {1'b1, k[PW-1:0]};
      end
    end
    return res;
  endfunction

  assign pick_s     = rr_pick(bus.req, ptr_q);
  assign pick_idx_s = pick_s[PW-1:0];

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    aborted_d = 1'b0;
    busy_d    = busy_q;
    load_d    = 1'b0;
    up_dn_d   = up_dn_q;
    data_d    = data_q;
    cto_d     = cto_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    case (state_q)
      S_IDLE: begin
        if (pick_s[PW]) begin
          state_d = S_LOAD;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
          busy_d  = 1'b1;
          load_d  = 1'b1;
          win_d   = pick_idx_s;
          data_d  = bus.req_start[32'(pick_idx_s) * WIDTH +: WIDTH];
          cto_d   = bus.req_target[32'(pick_idx_s) * WIDTH +: WIDTH];
          up_dn_d = bus.req_up[pick_idx_s];
        end else begin
          busy_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          ptr_d     = win_q;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // abort wins over a terminal count seen in the same cycle
        if (bus.abort) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          ptr_d     = win_q;
        end else if (bus.ctr_tercnt) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = win_q;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      up_dn_q   <= 1'b1;
      data_q    <= '0;
      cto_q     <= '0;
      ptr_q     <= PW'(NREQ - 1);
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      load_q    <= load_d;
      up_dn_q   <= up_dn_d;
      data_q    <= data_d;
      cto_q     <= cto_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.aborted      = aborted_q;
  assign bus.busy         = busy_q;
  assign bus.ctr_data     = data_q;
  assign bus.ctr_load     = load_q;
  assign bus.ctr_up_dn    = up_dn_q;
  assign bus.ctr_count_to = cto_q;
  // Combinational so the counter freezes on the target in the very cycle the flag appears.
  assign bus.ctr_cen      = (state_q == S_RUN) & ~bus.ctr_tercnt;
endmodule

// File: tb/tb_bictr_rr_sched.sv
// Self-checking bench: a stand-in counter, a run-level reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_bictr_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] cnt;
  int               errors = 0;
  int               checks = 0;

  bictr_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  bictr_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared up/down counter with count-to compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (bus.ctr_load) cnt <= bus.ctr_data;
    else if (bus.ctr_cen) cnt <= bus.ctr_up_dn ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign bus.ctr_tercnt = (cnt == bus.ctr_count_to);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a timeline offset t from the LOAD cycle (t=0) with n counting steps;
  // counting occupies t=1..n, the flag is seen at t=n+1 and done pulses at t=n+2.
  bit               m_act, m_ab, m_found;
  int               m_win, m_t, m_n, m_ptr, m_w;
  logic [WIDTH-1:0] m_data, m_cto, m_st;
  logic             m_up;
  logic [NREQ-1:0]  e_grant;

  initial begin
    m_act = 1'b0; m_ab = 1'b0; m_win = 0; m_t = 0; m_n = 0; m_ptr = NREQ - 1;
    m_data = '0; m_cto = '0; m_up = 1'b1;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_act = 1'b0; m_ab = 1'b0; m_ptr = NREQ - 1;
        m_data = '0; m_cto = '0; m_up = 1'b1;
      end else if (m_act) begin
        if (bus.abort && m_t <= m_n + 1) begin
          m_act = 1'b0; m_ab = 1'b1; m_ptr = m_win;
        end else if (m_t == m_n + 2) begin
          m_act = 1'b0; m_ab = 1'b0; m_ptr = m_win;
        end else begin
          m_t++; m_ab = 1'b0;
        end
      end else begin
        m_ab = 1'b0;
        m_found = 1'b0;
        for (int j = 1; j <= NREQ; j++) begin
          m_w = (m_ptr + j) % NREQ;
          if (!m_found && bus.req[m_w]) begin
            m_found = 1'b1;
            m_win = m_w;
          end
        end
        if (m_found) begin
          m_act  = 1'b1;
          m_t    = 0;
          m_st   = bus.req_start[m_win*WIDTH +: WIDTH];
          m_cto  = bus.req_target[m_win*WIDTH +: WIDTH];
          m_up   = bus.req_up[m_win];
          m_data = m_st;
          m_n    = m_up ? int'(4'(m_cto - m_st)) : int'(4'(m_st - m_cto));
        end
      end
      #1;
      e_grant = m_act ? (4'b0001 << m_win) : 4'b0000;
      chk("m_grant", 32'(bus.grant), 32'(e_grant));
      chk("m_busy", 32'(bus.busy), 32'(m_act));
      chk("m_load", 32'(bus.ctr_load), 32'(m_act && m_t == 0));
      chk("m_cen", 32'(bus.ctr_cen), 32'(m_act && m_t >= 1 && m_t <= m_n));
      chk("m_done", 32'(bus.done), (m_act && m_t == m_n + 2) ? 32'(e_grant) : 32'd0);
      chk("m_aborted", 32'(bus.aborted), 32'(m_ab));
      chk("m_data", 32'(bus.ctr_data), 32'(m_data));
      chk("m_count_to", 32'(bus.ctr_count_to), 32'(m_cto));
      chk("m_up_dn", 32'(bus.ctr_up_dn), 32'(m_up));
      if (m_act && m_t == m_n + 2) chk("m_cnt_at_done", 32'(cnt), 32'(m_cto));
    end
  end

  task automatic set_lane(input int i, input logic up, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t);
    bus.req_up[i] = up;
    bus.req_start[i*WIDTH +: WIDTH] = s;
    bus.req_target[i*WIDTH +: WIDTH] = t;
  endtask

  task automatic do_run(input int idx, input logic up, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t,
                        input int exp_cen, input logic [31:0] exp_seq, input int exp_lat);
    int loads, cens, lc, dc;
    logic [31:0] seq;
    logic [WIDTH-1:0] fin;
    bit got;
    loads = 0; cens = 0; lc = -1; dc = -100; seq = '0; fin = '0; got = 1'b0;
    @(negedge clk);
    set_lane(idx, up, s, t);
    bus.req[idx] = 1'b1;
    for (int c = 0; c < 80 && !got; c++) begin
      @(posedge clk); #2;
      if (bus.ctr_load) begin
        loads++; lc = c;
        chk("grant_at_load", 32'(bus.grant), 32'd1 << idx);
      end
      if (bus.ctr_cen) begin
        cens++; seq = {seq[27:0], cnt};
      end
      if (bus.done[idx]) begin
        got = 1'b1; dc = c; fin = cnt;
      end
    end
    @(negedge clk);
    bus.req[idx] = 1'b0;
    chk("run_finished", 32'(got), 32'd1);
    chk("load_cycles", 32'(loads), 32'd1);
    chk("cen_cycles", 32'(cens), 32'(exp_cen));
    chk("cen_sequence", seq, exp_seq);
    chk("final_count", 32'(fin), 32'(t));
    chk("load_to_done", 32'(dc - lc), 32'(exp_lat));
    @(posedge clk); #2;
    chk("grant_after_done", 32'(bus.grant), 32'd0);
    chk("done_single_pulse", 32'(bus.done), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 60 && !idle; c++) begin
      @(posedge clk); #2;
      if (!bus.busy) idle = 1'b1;
    end
    chk(name, 32'(idle), 32'd1);
  endtask

  initial begin
    int order[5];
    int ng, gi;
    bit seen;
    bus.req = '0; bus.req_up = '0; bus.req_start = '0; bus.req_target = '0; bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_up_dn", 32'(bus.ctr_up_dn), 32'd1);
    chk("rst_count_to", 32'(bus.ctr_count_to), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single up run, wrap-around down run, zero-length run.
    do_run(0, 1'b1, 4'd3, 4'd7, 4, 32'h3456, 6);
    do_run(2, 1'b0, 4'd1, 4'd14, 3, 32'h10F, 5);
    do_run(1, 1'b1, 4'd9, 4'd9, 0, 32'h0, 2);

    // Fairness from a fresh reset with all four requesting continuously.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, 4'd0, 4'd2);
    bus.req = 4'b1111;
    ng = 0;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      @(posedge clk); #2;
      if (bus.ctr_load) begin
        gi = -1;
        for (int k = 0; k < NREQ; k++) if (bus.grant[k]) gi = k;
        order[ng] = gi;
        ng++;
      end
    end
    @(negedge clk); bus.req = '0;
    chk("fair_grants", 32'(ng), 32'd5);
    chk("fair_0", 32'(order[0]), 32'd0);
    chk("fair_1", 32'(order[1]), 32'd1);
    chk("fair_2", 32'(order[2]), 32'd2);
    chk("fair_3", 32'(order[3]), 32'd3);
    chk("fair_4", 32'(order[4]), 32'd0);
    wait_idle("fair_idle");

    // Abort in the second RUN cycle of a 10-step run while requester 3 waits.
    @(negedge clk);
    set_lane(1, 1'b1, 4'd0, 4'd10);
    set_lane(3, 1'b0, 4'd5, 4'd3);
    bus.req = 4'b1010;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #2;
      if (bus.ctr_load) seen = 1'b1;
    end
    chk("abort_load_seen", 32'(seen), 32'd1);
    chk("abort_owner", 32'(bus.grant), 32'h2);
    @(posedge clk); #2; chk("abort_run1_cen", 32'(bus.ctr_cen), 32'd1);
    @(posedge clk); #2; chk("abort_run2_cen", 32'(bus.ctr_cen), 32'd1);
    @(negedge clk); bus.abort = 1'b1; bus.req[1] = 1'b0;
    @(posedge clk); #2;
    chk("aborted_pulse", 32'(bus.aborted), 32'd1);
    chk("abort_grant_drop", 32'(bus.grant), 32'd0);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    @(negedge clk); bus.abort = 1'b0;
    @(posedge clk); #2;
    chk("abort_next_grant", 32'(bus.grant), 32'h8);
    chk("aborted_one_cycle", 32'(bus.aborted), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk); #2;
      if (bus.done[3]) seen = 1'b1;
    end
    chk("abort_follow_done", 32'(seen), 32'd1);
    @(negedge clk); bus.req = '0;
    wait_idle("abort_idle");

    // Reset in the middle of a run.
    @(negedge clk);
    set_lane(1, 1'b1, 4'd0, 4'd12);
    bus.req = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #2;
      if (bus.ctr_cen) seen = 1'b1;
    end
    chk("rstrun_in_run", 32'(seen), 32'd1);
    @(negedge clk); reset = 1'b1; bus.req = '0;
    #1;
    chk("rstrun_grant", 32'(bus.grant), 32'd0);
    chk("rstrun_busy", 32'(bus.busy), 32'd0);
    chk("rstrun_done", 32'(bus.done), 32'd0);
    chk("rstrun_aborted", 32'(bus.aborted), 32'd0);
    chk("rstrun_load", 32'(bus.ctr_load), 32'd0);
    chk("rstrun_cen", 32'(bus.ctr_cen), 32'd0);
    chk("rstrun_up_dn", 32'(bus.ctr_up_dn), 32'd1);
    chk("rstrun_data", 32'(bus.ctr_data), 32'd0);
    @(negedge clk); reset = 1'b0;
    set_lane(2, 1'b1, 4'd3, 4'd4);
    bus.req = 4'b0100;
    @(posedge clk); #2;
    chk("rstrun_regrant", 32'(bus.grant), 32'h4);
    wait_idle("rstrun_idle");
    @(negedge clk); bus.req = '0;
    wait_idle("rstrun_idle2");

    // Randomized traffic, aborts and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 599) == 0);
      bus.req = 4'($urandom());
      bus.req_up = 4'($urandom());
      bus.req_start = 16'($urandom());
      bus.req_target = 16'($urandom());
      bus.abort = ($urandom_range(0, 24) == 0);
    end
    @(negedge clk);
    reset = 1'b0; bus.req = '0; bus.abort = 1'b0;
    repeat (25) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
